// File: rtl/vram_fill_writer.sv
// Rectangle-fill write engine for the 640x480 RGB444 VRAM: one pixel write per clock, row-major.
// Optional clipping to the visible area is enabled by defining VRAM_FILL_CLIP_EN.
module vram_fill_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [11:0] cmd_color,
    output logic        busy,
    output logic        done,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_wdata
);

`ifdef VRAM_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  x0_reg, w_reg, cx_reg;
    logic [8:0]  y0_reg, h_reg, cy_reg;
    logic [11:0] color_reg;

    logic        accept;
    logic        row_end;
    logic        last_pixel;
    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic        in_view;

    assign accept     = cmd_valid && (state_reg == IDLE);
    assign row_end    = (cx_reg == w_reg - 10'd1);
    assign last_pixel = row_end && (cy_reg == h_reg - 9'd1);

    // Keep the carry bit so wrapped coordinates still count as off-screen when clipping.
    assign x_sum   = {1'b0, x0_reg} + {1'b0, cx_reg};
    assign y_sum   = {1'b0, y0_reg} + {1'b0, cy_reg};
    assign in_view = (x_sum < 11'(H_RES)) && (y_sum < 10'(V_RES));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_w != 10'd0 && cmd_h != 9'd0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            x0_reg    <= '0;
            y0_reg    <= '0;
            w_reg     <= '0;
            h_reg     <= '0;
            color_reg <= '0;
            cx_reg    <= '0;
            cy_reg    <= '0;
        end else if (accept) begin
            x0_reg    <= cmd_x;
            y0_reg    <= cmd_y;
            w_reg     <= cmd_w;
            h_reg     <= cmd_h;
            color_reg <= cmd_color;
            cx_reg    <= '0;
            cy_reg    <= '0;
        end else if (state_reg == FILL) begin
            if (row_end) begin
                cx_reg <= '0;
                cy_reg <= cy_reg + 9'd1;
            end else begin
                cx_reg <= cx_reg + 10'd1;
            end
        end
    end

    // Outputs are decoded purely from registered state, so reset clears them at once.
    always_comb begin
        cmd_ready  = (state_reg == IDLE);
        busy       = (state_reg == FILL);
        done       = (state_reg == DONE);
        vram_we    = (state_reg == FILL) && (!CLIP_EN || in_view);
        vram_addr  = {x_sum[9:0], y_sum[8:0]};
        vram_wdata = color_reg;
    end

endmodule
